// File: rtl/axi_rt_sub_pkg.sv
// Shared types, response codes and data pattern helper for the RT-unit AXI subordinate.
package axi_rt_sub_pkg;

   localparam int unsigned AxiAddrWidth = 32;
   localparam int unsigned AxiDataWidth = 32;
   localparam int unsigned AxiIdWidth   = 2;
   localparam int unsigned AxiUserWidth = 1;
   localparam int unsigned LatWidth     = 8;

   typedef logic [LatWidth-1:0] lat_cnt_t;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_e;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   typedef struct packed {
      logic [AxiIdWidth-1:0]   id;
      logic [AxiAddrWidth-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
      logic [AxiUserWidth-1:0] user;
      logic [5:0]              atop;
   } axi_aw_t;

   typedef struct packed {
      logic [AxiDataWidth-1:0]   data;
      logic [AxiDataWidth/8-1:0] strb;
      logic                      last;
      logic [AxiUserWidth-1:0]   user;
   } axi_w_t;

   typedef struct packed {
      logic [AxiIdWidth-1:0]   id;
      logic [1:0]              resp;
      logic [AxiUserWidth-1:0] user;
   } axi_b_t;

   typedef struct packed {
      logic [AxiIdWidth-1:0]   id;
      logic [AxiAddrWidth-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      logic [1:0]              burst;
      logic [AxiUserWidth-1:0] user;
   } axi_ar_t;

   typedef struct packed {
      logic [AxiIdWidth-1:0]   id;
      logic [AxiDataWidth-1:0] data;
      logic [1:0]              resp;
      logic                    last;
      logic [AxiUserWidth-1:0] user;
   } axi_r_t;

   typedef struct packed {
      axi_aw_t aw;
      logic    aw_valid;
      axi_w_t  w;
      logic    w_valid;
      logic    b_ready;
      axi_ar_t ar;
      logic    ar_valid;
      logic    r_ready;
   } axi_req_t;

   typedef struct packed {
      logic   aw_ready;
      logic   ar_ready;
      logic   w_ready;
      logic   b_valid;
      axi_b_t b;
      logic   r_valid;
      axi_r_t r;
   } axi_resp_t;

   // One 32-bit lane of read data: address scrambled by the seed and the lane index.
   function automatic logic [31:0] lane_pattern(input logic [31:0] addr,
                                                input logic [31:0] seed,
                                                input int unsigned lane);
      return addr ^ seed ^ 32'(lane);
   endfunction

endpackage

// File: rtl/axi_rt_sub_burst_addr.sv
// Next beat address for FIXED / INCR / WRAP bursts.
module axi_rt_sub_burst_addr
   import axi_rt_sub_pkg::*;
#(
   parameter int unsigned AddrWidth = 32
) (
   input  logic [AddrWidth-1:0] addr,
   input  logic [7:0]           len,
   input  logic [2:0]           size,
   input  logic [1:0]           burst,
   output logic [AddrWidth-1:0] next_addr_c
);

   logic [AddrWidth-1:0] step;
   logic [AddrWidth-1:0] incr_addr;
   logic [AddrWidth-1:0] wrap_mask;

   // WRAP keeps the bits above the (len+1)<<size window and wraps the rest.
   always_comb begin
      step        = AddrWidth'(1) << size;
      incr_addr   = addr + step;
      wrap_mask   = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
      next_addr_c = incr_addr;
      case (burst)
         BurstFixed: next_addr_c = addr;
         BurstWrap:  next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default:    next_addr_c = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_rt_sub_responder.sv
// AXI4 subordinate endpoint with programmable response latency and transaction counters.
// Optional address window check: define AXI_RT_SUB_DECERR_EN.
module axi_rt_sub_responder
   import axi_rt_sub_pkg::*;
#(
   parameter int unsigned          AddrWidth   = 32,
   parameter int unsigned          DataWidth   = 32,
   parameter int unsigned          IdWidth     = 2,
   parameter int unsigned          UserWidth   = 1,
   parameter int unsigned          RespLatency = 4,
   parameter logic [31:0]          Seed        = 32'hA5A5_0000,
   parameter logic [AddrWidth-1:0] WinStart    = '0,
   parameter logic [AddrWidth-1:0] WinEnd      = '1,
   parameter type                  axi_req_t   = axi_rt_sub_pkg::axi_req_t,
   parameter type                  axi_resp_t  = axi_rt_sub_pkg::axi_resp_t
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  axi_req_t    slv_req_i,
   output axi_resp_t   slv_resp_o,
   output logic [31:0] num_writes_o,
   output logic [31:0] num_reads_o,
   output logic        busy_o
);

   localparam int unsigned NumLanes = DataWidth / 32;
   localparam bit          LatZero  = (RespLatency == 0);
   localparam lat_cnt_t    LatInit  = lat_cnt_t'(LatZero ? 0 : RespLatency - 1);

   // Write path state
   w_state_e             w_state;
   lat_cnt_t             w_lat;
   logic [7:0]           w_beat;
   logic [7:0]           w_len;
   logic [IdWidth-1:0]   w_id;
   logic [UserWidth-1:0] w_user;
   logic                 w_decerr;
   logic                 aw_ready;
   logic                 w_ready;
   logic                 b_valid;
   logic [1:0]           b_resp;

   // Read path state
   r_state_e             r_state;
   lat_cnt_t             r_lat;
   logic [AddrWidth-1:0] r_addr;
   logic [7:0]           r_len;
   logic [2:0]           r_size;
   logic [1:0]           r_burst;
   logic [7:0]           r_beat;
   logic                 r_decerr;
   logic [IdWidth-1:0]   r_id;
   logic [UserWidth-1:0] r_user;
   logic                 ar_ready;
   logic                 r_valid;
   logic [DataWidth-1:0] r_data;
   logic [1:0]           r_resp;
   logic                 r_last;

   logic                 aw_decerr_c;
   logic                 ar_decerr_c;
   logic                 w_last_beat_c;
   logic                 w_end_c;
   logic [1:0]           w_resp_c;
   logic [AddrWidth-1:0] r_next_addr_c;

   function automatic logic [DataWidth-1:0] beat_data(input logic [AddrWidth-1:0] addr,
                                                      input logic err);
      logic [DataWidth-1:0] data;
      data = '0;
      if (!err) begin
         for (int unsigned l = 0; l < NumLanes; l++) begin
            data[l*32 +: 32] = lane_pattern(32'(addr), Seed, l);
         end
      end
      return data;
   endfunction

   function automatic logic [1:0] read_resp(input logic err);
      return err ? RespDecErr : RespOkay;
   endfunction

`ifdef AXI_RT_SUB_DECERR_EN
   assign aw_decerr_c = (slv_req_i.aw.addr < WinStart) || (slv_req_i.aw.addr >= WinEnd);
   assign ar_decerr_c = (slv_req_i.ar.addr < WinStart) || (slv_req_i.ar.addr >= WinEnd);
`else
   logic unused_win;
   assign aw_decerr_c = 1'b0;
   assign ar_decerr_c = 1'b0;
   assign unused_win  = ^{WinStart, WinEnd, slv_req_i.aw.addr};
`endif

   // Write data and atomics are never looked at.
   logic unused_req;
   assign unused_req = ^{slv_req_i.w.data, slv_req_i.w.strb, slv_req_i.w.user,
                         slv_req_i.aw.atop, slv_req_i.aw.size, slv_req_i.aw.burst};

   // Burst end on last or beat count; a disagreement between them is a SLVERR.
   always_comb begin
      w_last_beat_c = (w_beat == w_len);
      w_end_c       = slv_req_i.w.last | w_last_beat_c;
      w_resp_c      = RespOkay;
      if (w_decerr) begin
         w_resp_c = RespDecErr;
      end else if (slv_req_i.w.last != w_last_beat_c) begin
         w_resp_c = RespSlvErr;
      end
   end

   axi_rt_sub_burst_addr #(
      .AddrWidth (AddrWidth)
   ) u_burst_addr (
      .addr        (r_addr),
      .len         (r_len),
      .size        (r_size),
      .burst       (r_burst),
      .next_addr_c (r_next_addr_c)
   );

   // Write FSM: absorb one burst, wait the response latency, hold B until accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state      <= W_IDLE;
         w_lat        <= '0;
         w_beat       <= '0;
         w_len        <= '0;
         w_id         <= '0;
         w_user       <= '0;
         w_decerr     <= 1'b0;
         aw_ready     <= 1'b1;
         w_ready      <= 1'b0;
         b_valid      <= 1'b0;
         b_resp       <= RespOkay;
         num_writes_o <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (slv_req_i.aw_valid) begin
                  w_id     <= slv_req_i.aw.id;
                  w_len    <= slv_req_i.aw.len;
                  w_user   <= slv_req_i.aw.user;
                  w_decerr <= aw_decerr_c;
                  w_beat   <= '0;
                  aw_ready <= 1'b0;
                  w_ready  <= 1'b1;
                  w_state  <= W_DATA;
               end
            end
            W_DATA: begin
               if (slv_req_i.w_valid) begin
                  if (w_end_c) begin
                     w_ready <= 1'b0;
                     b_resp  <= w_resp_c;
                     if (LatZero) begin
                        b_valid <= 1'b1;
                        w_state <= W_RESP;
                     end else begin
                        w_lat   <= LatInit;
                        w_state <= W_LAT;
                     end
                  end else begin
                     w_beat <= w_beat + 8'd1;
                  end
               end
            end
            W_LAT: begin
               if (w_lat == '0) begin
                  b_valid <= 1'b1;
                  w_state <= W_RESP;
               end else begin
                  w_lat <= w_lat - lat_cnt_t'(1);
               end
            end
            W_RESP: begin
               if (slv_req_i.b_ready) begin
                  b_valid      <= 1'b0;
                  aw_ready     <= 1'b1;
                  num_writes_o <= num_writes_o + 32'd1;
                  w_state      <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read FSM: wait the response latency, then stream len+1 address-derived beats.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= R_IDLE;
         r_lat       <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_size      <= '0;
         r_burst     <= '0;
         r_beat      <= '0;
         r_decerr    <= 1'b0;
         r_id        <= '0;
         r_user      <= '0;
         ar_ready    <= 1'b1;
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_resp      <= RespOkay;
         r_last      <= 1'b0;
         num_reads_o <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (slv_req_i.ar_valid) begin
                  r_addr   <= slv_req_i.ar.addr;
                  r_len    <= slv_req_i.ar.len;
                  r_size   <= slv_req_i.ar.size;
                  r_burst  <= slv_req_i.ar.burst;
                  r_id     <= slv_req_i.ar.id;
                  r_user   <= slv_req_i.ar.user;
                  r_decerr <= ar_decerr_c;
                  r_beat   <= '0;
                  ar_ready <= 1'b0;
                  if (LatZero) begin
                     r_valid <= 1'b1;
                     r_data  <= beat_data(slv_req_i.ar.addr, ar_decerr_c);
                     r_resp  <= read_resp(ar_decerr_c);
                     r_last  <= (slv_req_i.ar.len == 8'd0);
                     r_state <= R_DATA;
                  end else begin
                     r_lat   <= LatInit;
                     r_state <= R_LAT;
                  end
               end
            end
            R_LAT: begin
               if (r_lat == '0) begin
                  r_valid <= 1'b1;
                  r_data  <= beat_data(r_addr, r_decerr);
                  r_resp  <= read_resp(r_decerr);
                  r_last  <= (r_len == 8'd0);
                  r_state <= R_DATA;
               end else begin
                  r_lat <= r_lat - lat_cnt_t'(1);
               end
            end
            R_DATA: begin
               if (slv_req_i.r_ready) begin
                  if (r_last) begin
                     r_valid     <= 1'b0;
                     r_last      <= 1'b0;
                     ar_ready    <= 1'b1;
                     num_reads_o <= num_reads_o + 32'd1;
                     r_state     <= R_IDLE;
                  end else begin
                     r_addr <= r_next_addr_c;
                     r_beat <= r_beat + 8'd1;
                     r_data <= beat_data(r_next_addr_c, r_decerr);
                     r_last <= ((r_beat + 8'd1) == r_len);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Pack the registered handshake and payload signals onto the response bus.
   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = aw_ready;
      slv_resp_o.ar_ready = ar_ready;
      slv_resp_o.w_ready  = w_ready;
      slv_resp_o.b_valid  = b_valid;
      slv_resp_o.b.id     = w_id;
      slv_resp_o.b.resp   = b_resp;
      slv_resp_o.b.user   = w_user;
      slv_resp_o.r_valid  = r_valid;
      slv_resp_o.r.id     = r_id;
      slv_resp_o.r.data   = r_data;
      slv_resp_o.r.resp   = r_resp;
      slv_resp_o.r.last   = r_last;
      slv_resp_o.r.user   = r_user;
   end

   assign busy_o = (w_state != W_IDLE) || (r_state != R_IDLE);

endmodule
